// File: rtl/wptr_full_level.sv
// wptr_full_level: async-FIFO write-side pointer, full/almost-full flags, fill level and sticky overflow.
// The read pointer crosses in through a SYNC_STAGES flop chain, so flags and level are pessimistic.
module wptr_full_level #(
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [ASIZE:0]   wq_rptr,
    input  logic [ASIZE:0]   waf_thresh,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             wafull,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);
    logic [ASIZE:0] sync_q [SYNC_STAGES];
    logic [ASIZE:0] wq2_rptr, rbin_s, wbin, wbinnext, wgraynext, level_next;
    logic           wen, full_next;

    always_ff @(posedge wclk or negedge wrst_n)
        if (!wrst_n) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q[0] <= wq_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end

    assign wq2_rptr = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i <= ASIZE; i++) begin : g_g2b
        assign rbin_s[i] = ^wq2_rptr[ASIZE:i];
    end

    assign wen        = winc & ~wfull;
    assign wbinnext   = wbin + (ASIZE+1)'(wen);
    assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
    assign level_next = wbinnext - rbin_s;
    assign full_next  = wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
    assign waddr      = wbin[ASIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n)
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wfull     <= 1'b0;
            wafull    <= 1'b0;
            wlevel    <= '0;
            woverflow <= 1'b0;
        end else begin
            wbin      <= wbinnext;
            wptr      <= wgraynext;
            wfull     <= full_next;
            wafull    <= level_next >= waf_thresh;
            wlevel    <= level_next;
            woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
        end
endmodule

// File: tb/tb_wptr_full_level.sv
// tb_wptr_full_level: directed vector table, corner sequences and randomized run against a count-based model.
module tb_wptr_full_level;
    localparam int A = 4;

    logic         wclk = 0, wrst_n = 0, winc = 0, wovf_clr = 0;
    logic [A:0]   wq_rptr = '0, waf_thresh = 12;
    logic [A-1:0] waddr;
    logic [A:0]   wptr, wlevel;
    logic         wfull, wafull, woverflow;

    int checks = 0, errors = 0;
    int wc = 0, wtot = 0, rc = 0, m_lvl = 0;
    int rh [2] = '{0, 0};
    bit m_full = 0, m_af = 0, m_ovf = 0;

    typedef struct {bit inc; bit clr; int lvl; bit full; bit af; bit ovf; int addr;} vec_t;
    vec_t tv [20];

    always #5 wclk = ~wclk;

    wptr_full_level #(.ASIZE(A), .SYNC_STAGES(2)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq_rptr(wq_rptr),
        .waf_thresh(waf_thresh), .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow)
    );

    function automatic logic [A:0] gray(input int b);
        logic [A:0] v;
        v = b[A:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic set_r(input int r);
        rc = r;
        wq_rptr = gray(r % 32);
    endtask

    task automatic do_reset();
        wrst_n = 0;
        #1;
        chk("rst_waddr", waddr, 0);
        chk("rst_wptr", wptr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_wafull", wafull, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_wovf", woverflow, 0);
        wc = 0; wtot = 0; m_lvl = 0; rh = '{0, 0};
        m_full = 0; m_af = 0; m_ovf = 0;
        @(negedge wclk);
        wrst_n = 1;
    endtask

    // Model: level = accepted writes minus the read count seen two edges ago.
    task automatic cyc();
        bit en;
        logic [A:0] prev;
        en = winc && !m_full;
        m_ovf = (winc && m_full) ? 1'b1 : (wovf_clr ? 1'b0 : m_ovf);
        wc = (wc + int'(en)) % 32;
        wtot += int'(en);
        m_lvl = (wc - rh[1] + 32) % 32;
        m_full = m_lvl == 16;
        m_af = m_lvl >= int'(waf_thresh);
        rh[1] = rh[0];
        rh[0] = rc % 32;
        prev = wptr;
        @(posedge wclk);
        #1;
        chk("waddr", waddr, wc % 16);
        chk("wptr", wptr, gray(wc));
        chk("gray_step", ($countones(wptr ^ prev) <= 1), 1);
        chk("wfull", wfull, m_full);
        chk("wafull", wafull, m_af);
        chk("wlevel", wlevel, m_lvl);
        chk("wovf", woverflow, m_ovf);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tv[i] = '{1, 0, i + 1, i == 15, i + 1 >= 12, 0, (i + 1) % 16};
        tv[16] = '{1, 0, 16, 1, 1, 1, 0};
        tv[17] = '{0, 1, 16, 1, 1, 0, 0};
        tv[18] = '{1, 1, 16, 1, 1, 1, 0};
        tv[19] = '{0, 0, 16, 1, 1, 1, 0};

        waf_thresh = 0;
        do_reset();
        cyc();
        chk("thr0_wafull", wafull, 1);
        chk("thr0_level", wlevel, 0);

        waf_thresh = 12;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            winc = tv[i].inc;
            wovf_clr = tv[i].clr;
            cyc();
            chk("tv_level", wlevel, tv[i].lvl);
            chk("tv_full", wfull, tv[i].full);
            chk("tv_afull", wafull, tv[i].af);
            chk("tv_ovf", woverflow, tv[i].ovf);
            chk("tv_addr", waddr, tv[i].addr);
            if (i >= 15) chk("tv_wptr", wptr, 5'b11000);
        end
        winc = 0; wovf_clr = 0;

        waf_thresh = 17;
        cyc();
        chk("thr17_wafull", wafull, 0);
        chk("thr17_full", wfull, 1);
        waf_thresh = 12;

        do_reset();
        winc = 1;
        for (int i = 0; i < 16; i++) cyc();
        winc = 0;
        chk("refill_full", wfull, 1);
        set_r(4);
        cyc();
        chk("drain_e1_full", wfull, 1);
        cyc();
        chk("drain_e2_full", wfull, 1);
        chk("drain_e2_level", wlevel, 16);
        cyc();
        chk("drain_e3_full", wfull, 0);
        chk("drain_e3_level", wlevel, 12);

        winc = 1;
        for (int i = 0; i < 40; i++) begin
            if (wtot - rc > 3 || ($urandom_range(0, 1) == 1 && rc < wtot)) set_r(rc + 1);
            cyc();
            chk("wrap_nofull", wfull, 0);
        end

        for (int i = 0; i < 400; i++) begin
            winc = 1'($urandom_range(0, 1));
            wovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) waf_thresh = 5'($urandom_range(0, 18));
            if (rc < wtot && $urandom_range(0, 2) == 0) set_r(rc + 1);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
